mult_hilo_seq: RTL and testbench

//   Sequencer for the iterative multiplier and the HI/LO register pair behind mult/multu/mfhi/mflo.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/mult_shift_add_core.sv | 56 +++++
 rtl/mult_hilo_seq.sv | 106 ++++++++++
 tb/tb_mult_hilo_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the HI/LO multiply sequencer.
package mult_pkg;

   localparam int MULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] MF_NONE = 2'b00;
   localparam logic [1:0] MF_LO   = 2'b01;
   localparam logic [1:0] MF_HI   = 2'b10;

   function automatic int cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   localparam int CNT_W = cnt_w(MULT_WIDTH);

endpackage

// File: rtl/mult_shift_add_core.sv
// Shift-add multiply datapath: operand magnitudes, accumulator and the final sign fix-up.
module mult_shift_add_core
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_load,
   input  logic               i_step,
   input  logic               i_commit,
   input  logic               i_signed,
   input  logic [WIDTH-1:0]   i_srca,
   input  logic [WIDTH-1:0]   i_srcb,
   output logic [2*WIDTH-1:0] o_product
);

   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic               r_neg;

   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_shifted;

   // The most negative value negates to itself, which read as unsigned is exactly 2^(WIDTH-1).
   assign w_abs_a = (i_signed && i_srca[WIDTH-1]) ? -i_srca : i_srca;
   assign w_abs_b = (i_signed && i_srcb[WIDTH-1]) ? -i_srcb : i_srcb;

   assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
   assign w_shifted = {w_sum, r_acc[WIDTH-1:1]};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_neg    <= 1'b0;
      end else if (i_load) begin
         r_acc    <= '0;
         r_mcand  <= w_abs_a;
         r_mplier <= w_abs_b;
         r_neg    <= i_signed & (i_srca[WIDTH-1] ^ i_srcb[WIDTH-1]);
      end else if (i_step) begin
         r_acc    <= w_shifted;
         r_mplier <= r_mplier >> 1;
      end
   end

   assign o_product = !i_commit ? '0 : (r_neg ? -r_acc : r_acc);

endmodule

// File: rtl/mult_hilo_seq.sv
// Execute-stage multiply sequencer: FSM, cycle counter, HI/LO registers, stall and mf read mux.
module mult_hilo_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_mult,
   input  logic             signed_mult,
   input  logic [1:0]       mf_reg,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic [WIDTH-1:0] mf_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall
);

   localparam int CNT_BITS = cnt_w(WIDTH);

   state_t              r_state;
   state_t              w_next_state;
   logic [CNT_BITS-1:0] r_count;
   logic [WIDTH-1:0]    r_hi;
   logic [WIDTH-1:0]    r_lo;
   logic                w_load;
   logic                w_step;
   logic                w_commit;
   logic [2*WIDTH-1:0]  w_product;

   mult_shift_add_core #(.WIDTH(WIDTH)) u_core (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_load    (w_load),
      .i_step    (w_step),
      .i_commit  (w_commit),
      .i_signed  (signed_mult),
      .i_srca    (srca),
      .i_srcb    (srcb),
      .o_product (w_product)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next_state;
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_mult) begin
               w_load       = 1'b1;
               w_next_state = RUN;
            end
         end
         RUN: begin
            w_step = 1'b1;
            if (r_count == CNT_BITS'(WIDTH-1)) w_next_state = DONE;
         end
         DONE: begin
            w_commit     = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    r_count <= '0;
      else if (w_load) r_count <= '0;
      else if (w_step) r_count <= r_count + 1'b1;
   end

   // HI/LO are written as a pair so a reader never sees half of a product.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_commit) begin
         r_hi <= w_product[2*WIDTH-1:WIDTH];
         r_lo <= w_product[WIDTH-1:0];
      end
   end

   assign hi    = r_hi;
   assign lo    = r_lo;
   assign busy  = (r_state != IDLE);
   assign stall = busy & (start_mult | (mf_reg == MF_HI) | (mf_reg == MF_LO));

   always_comb begin
      mf_data = '0;
      case (mf_reg)
         MF_HI:   mf_data = r_hi;
         MF_LO:   mf_data = r_lo;
         default: mf_data = '0;
      endcase
   end

endmodule

// File: tb/tb_mult_hilo_seq.sv
// Self-checking bench for mult_hilo_seq against a plain-arithmetic product model.
module tb_mult_hilo_seq;

   localparam int W = 32;
   localparam int LAT = W + 1;

   logic         clk;
   logic         reset_n;
   logic         start_mult;
   logic         signed_mult;
   logic [1:0]   mf_reg;
   logic [W-1:0] srca;
   logic [W-1:0] srcb;
   logic [W-1:0] mf_data;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         stall;

   int n_checks = 0;
   int n_pass   = 0;

   logic [W-1:0] m_hi;
   logic [W-1:0] m_lo;

   mult_hilo_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_mult  (start_mult),
      .signed_mult (signed_mult),
      .mf_reg      (mf_reg),
      .srca        (srca),
      .srcb        (srcb),
      .mf_data     (mf_data),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .stall       (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   function automatic logic [63:0] ref_prod(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called one step after a posedge with the unit idle; returns one step after the start edge.
   task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      signed_mult = s;
      srca        = a;
      srcb        = b;
      start_mult  = 1'b1;
      check("start_idle_no_stall", {63'b0, stall}, 64'd0);
      step();
      start_mult  = 1'b0;
   endtask

   // Counts busy cycles, stall misses and any HI/LO movement while busy (bounded wait).
   task automatic wait_done(output int cycles, output int stall_miss, output int hilo_moved);
      cycles = 0;
      stall_miss = 0;
      hilo_moved = 0;
      while (busy && cycles < 200) begin
         if (!stall && (start_mult || mf_reg == 2'b01 || mf_reg == 2'b10)) stall_miss++;
         if (hi !== m_hi || lo !== m_lo) hilo_moved++;
         cycles++;
         step();
      end
   endtask

   task automatic run_mult(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      int cyc, miss, moved;
      logic [63:0] p;
      p = ref_prod(s, a, b);
      start_op(s, a, b);
      wait_done(cyc, miss, moved);
      check({tag, "_latency"}, 64'(cyc), 64'(LAT));
      check({tag, "_hilo_held"}, 64'(moved), 64'd0);
      check({tag, "_hilo"}, {hi, lo}, p);
      m_hi = p[63:32];
      m_lo = p[31:0];
   endtask

   initial begin
      int cyc, miss, moved;
      logic [63:0] p1, p2;
      logic [W-1:0] ra, rb;
      logic rs;

      reset_n     = 1'b0;
      start_mult  = 1'b0;
      signed_mult = 1'b0;
      mf_reg      = 2'b00;
      srca        = '0;
      srcb        = '0;
      m_hi        = '0;
      m_lo        = '0;
      repeat (3) step();
      check("reset_hilo", {hi, lo}, 64'd0);
      check("reset_busy", {62'b0, busy, stall}, 64'd0);
      check("reset_mf", 64'(mf_data), 64'd0);
      reset_n = 1'b1;
      step();

      run_mult("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      run_mult("mult_m3x7", 1'b1, 32'hFFFF_FFFD, 32'd7);
      check("mult_m3x7_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_mult("mult_minmin", 1'b1, 32'h8000_0000, 32'h8000_0000);
      check("mult_minmin_const", {hi, lo}, 64'h4000_0000_0000_0000);
      run_mult("mult_zero", 1'b1, 32'd0, 32'h1234_5678);

      // mflo issued right behind a mult must stall until the product lands.
      start_op(1'b1, 32'd6, 32'd7);
      mf_reg = 2'b01;
      wait_done(cyc, miss, moved);
      check("mflo_wait_latency", 64'(cyc), 64'(LAT));
      check("mflo_wait_stall", 64'(miss), 64'd0);
      check("mflo_wait_data", 64'(mf_data), 64'd42);
      check("mflo_wait_nostall", {63'b0, stall}, 64'd0);
      m_hi = '0;
      m_lo = 32'd42;
      mf_reg = 2'b10;
      #1;
      check("mfhi_idle", 64'(mf_data), 64'(m_hi));
      check("mfhi_idle_nostall", {63'b0, stall}, 64'd0);

      // A second start while busy is held off and must not disturb the first operands.
      p1 = ref_prod(1'b0, 32'd1000, 32'd3000);
      p2 = ref_prod(1'b1, 32'hFFFF_FF00, 32'd77);
      mf_reg = 2'b00;
      start_op(1'b0, 32'd1000, 32'd3000);
      signed_mult = 1'b1;
      srca        = 32'hFFFF_FF00;
      srcb        = 32'd77;
      start_mult  = 1'b1;
      wait_done(cyc, miss, moved);
      check("restart_first_latency", 64'(cyc), 64'(LAT));
      check("restart_stall", 64'(miss), 64'd0);
      check("restart_first_hilo", {hi, lo}, p1);
      check("restart_idle_nostall", {63'b0, stall}, 64'd0);
      m_hi = p1[63:32];
      m_lo = p1[31:0];
      step();
      start_mult = 1'b0;
      wait_done(cyc, miss, moved);
      check("restart_second_latency", 64'(cyc), 64'(LAT));
      check("restart_second_hilo", {hi, lo}, p2);
      m_hi = p2[63:32];
      m_lo = p2[31:0];

      // mf codes that do not select a register read as zero and never stall.
      start_op(1'b0, 32'd9, 32'd9);
      mf_reg = 2'b11;
      #1;
      check("mf_illegal_busy", {31'b0, stall, mf_data}, 64'd0);
      mf_reg = 2'b00;
      #1;
      check("mf_none_busy", {31'b0, stall, mf_data}, 64'd0);
      wait_done(cyc, miss, moved);
      m_hi = '0;
      m_lo = 32'd81;
      check("mf_busy_product", {hi, lo}, {m_hi, m_lo});

      // Asynchronous reset partway through a multiply.
      start_op(1'b1, 32'h0000_1234, 32'hFFFF_0000);
      repeat (10) step();
      reset_n = 1'b0;
      #1;
      check("midreset_busy", {63'b0, busy}, 64'd0);
      check("midreset_hilo", {hi, lo}, 64'd0);
      m_hi = '0;
      m_lo = '0;
      step();
      reset_n = 1'b1;
      step();
      run_mult("post_reset", 1'b1, 32'h7FFF_FFFF, 32'h8000_0001);

      for (int i = 0; i < 12; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = $urandom;
         if (i == 0) ra = 32'h8000_0000;
         run_mult($sformatf("rand%0d", i), rs, ra, rb);
         mf_reg = 2'($urandom_range(0, 3));
         #1;
         check($sformatf("rand%0d_mf", i), 64'(mf_data),
               (mf_reg == 2'b10) ? 64'(m_hi) : (mf_reg == 2'b01) ? 64'(m_lo) : 64'd0);
         mf_reg = 2'b00;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
